// File: rtl/onehot_scan_decoder_if.sv
// Signal bundle for the one-hot scan decoder.
// The master drives the controls and the select, and receives the strobe outputs.
interface onehot_scan_decoder_if #(
    parameter int SEL_W   = 4,
    parameter int OUT_W   = 16,
    parameter int DWELL_W = 8
);
    logic               enable;
    logic               mode;
    logic [SEL_W-1:0]   in;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   index;
    logic               valid;
    logic               oor;
    logic               wrap;

    modport master (
        output enable, mode, in, dwell,
        input  out, index, valid, oor, wrap
    );

    modport slave (
        input  enable, mode, in, dwell,
        output out, index, valid, oor, wrap
    );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Binary-to-one-hot decoder with a registered output and an autonomous scan
// mode that walks the strobe across OUT_W positions. Each position is held
// for dwell+1 cycles. Out-of-range select detection, a wrap pulse and an
// index readback are also provided.
module onehot_scan_decoder #(
    parameter int SEL_W   = 4,
    parameter int OUT_W   = 16,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    onehot_scan_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Position at which the scan wraps back to zero. The wrap point follows
    // OUT_W, not 2**SEL_W.
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(OUT_W - 1);
    // One bit wider than the select, so that OUT_W == 2**SEL_W still fits.
    localparam logic [SEL_W:0]   OUT_W_EXT = (SEL_W + 1)'(OUT_W);

    state_t             state_reg, state_next;
    logic [OUT_W-1:0]   out_reg, out_next;
    logic [SEL_W-1:0]   index_reg, index_next;
    logic               valid_reg, valid_next;
    logic               oor_reg, oor_next;
    logic               wrap_reg, wrap_next;
    logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;

    // Next-state and next-output logic. The next state depends only on
    // enable and mode. The outputs are computed for the state being entered.
    always_comb begin
        state_next     = IDLE;
        out_next       = '0;
        index_next     = index_reg;
        valid_next     = 1'b0;
        oor_next       = 1'b0;
        wrap_next      = 1'b0;
        dwell_cnt_next = dwell_cnt_reg;

        if (!bus.enable) begin
            state_next = IDLE;
        end else if (bus.mode) begin
            state_next = SCAN;
        end else begin
            state_next = DIRECT;
        end

        case (state_next)
            DIRECT: begin
                dwell_cnt_next = '0;
                index_next     = bus.in;
                if ({1'b0, bus.in} < OUT_W_EXT) begin
                    out_next   = OUT_W'(1) << bus.in;
                    valid_next = 1'b1;
                end else begin
                    oor_next   = 1'b1;
                end
            end
            SCAN: begin
                valid_next = 1'b1;
                if (state_reg != SCAN) begin
                    // Entering the scan always restarts it at position 0.
                    index_next     = '0;
                    out_next       = OUT_W'(1);
                    dwell_cnt_next = '0;
                end else if (dwell_cnt_reg >= bus.dwell) begin
                    // The >= compare lets a lowered dwell take effect at once.
                    dwell_cnt_next = '0;
                    if (index_reg == LAST_IDX) begin
                        index_next = '0;
                        wrap_next  = 1'b1;
                    end else begin
                        index_next = index_reg + SEL_W'(1);
                    end
                    out_next = OUT_W'(1) << index_next;
                end else begin
                    dwell_cnt_next = dwell_cnt_reg + DWELL_W'(1);
                    out_next       = out_reg;
                end
            end
            default: begin
                // IDLE: the strobe is off, index and dwell count are held.
            end
        endcase
    end

    // State and output registers. Reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            out_reg       <= '0;
            index_reg     <= '0;
            valid_reg     <= 1'b0;
            oor_reg       <= 1'b0;
            wrap_reg      <= 1'b0;
            dwell_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            out_reg       <= out_next;
            index_reg     <= index_next;
            valid_reg     <= valid_next;
            oor_reg       <= oor_next;
            wrap_reg      <= wrap_next;
            dwell_cnt_reg <= dwell_cnt_next;
        end
    end

    assign bus.out   = out_reg;
    assign bus.index = index_reg;
    assign bus.valid = valid_reg;
    assign bus.oor   = oor_reg;
    assign bus.wrap  = wrap_reg;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Testbench for onehot_scan_decoder. Two instances share one stimulus:
// one with OUT_W=16 and one with OUT_W=12, which is not a power of two.
// A behavioural model is compared against both instances on every cycle.
module tb_onehot_scan_decoder;

    localparam int SEL_W   = 4;
    localparam int DWELL_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic               enable = 1'b0;
    logic               mode   = 1'b0;
    logic [SEL_W-1:0]   in_sel = '0;
    logic [DWELL_W-1:0] dwell  = '0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    onehot_scan_decoder_if #(.SEL_W(SEL_W), .OUT_W(16), .DWELL_W(DWELL_W)) bus16 ();
    onehot_scan_decoder_if #(.SEL_W(SEL_W), .OUT_W(12), .DWELL_W(DWELL_W)) bus12 ();

    assign bus16.enable = enable;
    assign bus16.mode   = mode;
    assign bus16.in     = in_sel;
    assign bus16.dwell  = dwell;
    assign bus12.enable = enable;
    assign bus12.mode   = mode;
    assign bus12.in     = in_sel;
    assign bus12.dwell  = dwell;

    onehot_scan_decoder #(.SEL_W(SEL_W), .OUT_W(16), .DWELL_W(DWELL_W)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    onehot_scan_decoder #(.SEL_W(SEL_W), .OUT_W(12), .DWELL_W(DWELL_W)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The model state is kept per instance: 0 means idle, 1 means direct, 2 means scan.
    // held counts the cycles for which the current scan position has been shown.
    int m_ow   [2] = '{16, 12};
    int m_st   [2] = '{0, 0};
    int m_idx  [2] = '{0, 0};
    int m_held [2] = '{0, 0};
    int m_wrap [2] = '{0, 0};

    function automatic void model_reset(int k);
        m_st[k] = 0; m_idx[k] = 0; m_held[k] = 0; m_wrap[k] = 0;
    endfunction

    function automatic void model_step(int k);
        m_wrap[k] = 0;
        if (!enable) begin
            m_st[k] = 0;
        end else if (!mode) begin
            m_st[k]  = 1;
            m_idx[k] = int'(in_sel);
        end else if (m_st[k] != 2) begin
            m_st[k] = 2; m_idx[k] = 0; m_held[k] = 1;
        end else if (m_held[k] >= int'(dwell) + 1) begin
            m_wrap[k] = (m_idx[k] == m_ow[k] - 1) ? 1 : 0;
            m_idx[k]  = (m_idx[k] + 1) % m_ow[k];
            m_held[k] = 1;
        end else begin
            m_held[k]++;
        end
    endfunction

    function automatic logic [31:0] exp_out(int k);
        if (m_st[k] == 2 || (m_st[k] == 1 && m_idx[k] < m_ow[k]))
            return 32'd1 << m_idx[k];
        return 32'd0;
    endfunction

    // Reference model update: reset acts immediately, otherwise the model steps on each rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0); model_reset(1);
        end else begin
            model_step(0); model_step(1);
        end
    end

    // Compare process: checks both instances against the model just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("out16",   32'(bus16.out),   exp_out(0));
            chk("index16", 32'(bus16.index), 32'(m_idx[0]));
            chk("valid16", 32'(bus16.valid), 32'(exp_out(0) != 0));
            chk("oor16",   32'(bus16.oor),   32'(m_st[0] == 1 && m_idx[0] >= 16));
            chk("wrap16",  32'(bus16.wrap),  32'(m_wrap[0]));
            chk("out12",   32'(bus12.out),   exp_out(1));
            chk("index12", 32'(bus12.index), 32'(m_idx[1]));
            chk("valid12", 32'(bus12.valid), 32'(exp_out(1) != 0));
            chk("oor12",   32'(bus12.oor),   32'(m_st[1] == 1 && m_idx[1] >= 12));
            chk("wrap12",  32'(bus12.wrap),  32'(m_wrap[1]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int first_wrap;
        // Reset with the clock running.
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        step(3);
        chk("rst_out",   32'(bus16.out),   32'h0);
        chk("rst_index", 32'(bus16.index), 32'h0);
        chk("rst_valid", 32'(bus16.valid), 32'h0);

        // Direct decode: each select is held for 2 cycles.
        rst = 1'b0; enable = 1'b1; mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_sel = SEL_W'(i);
            step(1);
            chk($sformatf("dir_out_%0d", i), 32'(bus16.out), 32'd1 << i);
            chk($sformatf("dir_oor_%0d", i), 32'(bus16.oor), 32'h0);
            step(1);
        end

        // Out of range on the OUT_W=12 instance.
        in_sel = 4'd13; step(1);
        chk("oor12_out",   32'(bus12.out),   32'h0);
        chk("oor12_flag",  32'(bus12.oor),   32'h1);
        chk("oor12_index", 32'(bus12.index), 32'd13);
        chk("oor12_valid", 32'(bus12.valid), 32'h0);
        in_sel = 4'd11; step(1);
        chk("in11_out12",  32'(bus12.out),   32'h800);
        chk("in11_oor12",  32'(bus12.oor),   32'h0);

        // Scan with dwell=2: each position shows for 3 cycles and the scan wraps after 48 cycles.
        mode = 1'b1; dwell = 8'd2;
        first_wrap = -1; n = 0;
        for (int c = 0; c <= 50; c++) begin
            step(1);
            if (c < 3)  chk($sformatf("scan_hold_%0d", c), 32'(bus16.out), 32'h1);
            if (c == 3) chk("scan_adv", 32'(bus16.out), 32'h2);
            if (bus16.wrap) begin
                n++;
                if (first_wrap < 0) first_wrap = c;
            end
        end
        chk("wrap_count_d2", 32'(n), 32'd1);
        chk("wrap_at_48",    32'(first_wrap), 32'd48);

        // Scan with dwell=0: the index advances on every cycle, so there are 2 wraps in 32 cycles.
        dwell = 8'd0; step(2);
        n = 0;
        for (int c = 0; c < 32; c++) begin
            if (bus16.wrap) n++;
            step(1);
        end
        chk("wrap_count_d0", 32'(n), 32'd2);

        // Enable gating.
        enable = 1'b0; step(1);
        enable = 1'b1; step(1);
        step(5);
        chk("gate_idx5", 32'(bus16.index), 32'd5);
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(1);
            chk("gate_out",   32'(bus16.out),   32'h0);
            chk("gate_valid", 32'(bus16.valid), 32'h0);
        end
        enable = 1'b1; step(1);
        chk("reen_index", 32'(bus16.index), 32'h0);
        chk("reen_out",   32'(bus16.out),   32'h1);

        // Live dwell change: dwell=200, then lower it to 10 once dwell_cnt reaches 50.
        enable = 1'b0; step(1);
        enable = 1'b1; dwell = 8'd200; step(1);
        step(50);
        chk("live_idx0", 32'(bus16.index), 32'h0);
        dwell = 8'd10; step(1);
        chk("live_adv", 32'(bus16.index), 32'h1);
        n = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus16.index == 4'd1) n++;
            step(1);
        end
        chk("live_hold11", 32'(n), 32'd11);

        // Randomised operation.
        for (int c = 0; c < 1500; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            in_sel = SEL_W'($urandom);
            if ($urandom_range(0, 9) == 0) dwell = DWELL_W'($urandom_range(0, 4));
            step(1);
        end

        // Asynchronous reset asserted between clock edges at index 7.
        enable = 1'b0; step(1);
        enable = 1'b1; mode = 1'b1; dwell = 8'd0; step(1);
        step(7);
        chk("pre_rst_idx7", 32'(bus16.index), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk("arst_out",   32'(bus16.out),   32'h0);
        chk("arst_index", 32'(bus16.index), 32'h0);
        chk("arst_wrap",  32'(bus16.wrap),  32'h0);
        chk("arst_valid", 32'(bus16.valid), 32'h0);
        step(2);
        rst = 1'b0; step(1);
        chk("post_rst_out", 32'(bus16.out), 32'h1);
        step(3);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
